// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative restoring divider for the MIPS-style HI/LO path.
//
// Signed or unsigned division, one quotient bit per clock. The operands are
// latched as magnitudes, divided unsigned, and then sign-corrected on the way
// out. A divide-by-zero returns all zeros and takes a short two-edge path.
//
// Ports
//   clk           : clock; all state changes on the rising edge
//   rst           : asynchronous active-low reset
//   signed_div_i  : 1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     : dividend
//   opdata2_i     : divisor
//   start_i       : request, held high by the execute stage until ready_o is seen
//   annul_i       : cancels an in-flight or requested operation
//   result_o      : {remainder, quotient}; upper half -> HI, lower half -> LO
//   ready_o       : high while result_o holds a freshly completed result
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // dvd_q starts as the dividend magnitude; quotient bits are shifted in at
    // the bottom as dividend bits leave the top, so after WIDTH steps it holds
    // the unsigned quotient.
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    // Stored remainder is always below the divisor, so WIDTH bits suffice;
    // the shifted partial remainder needs the extra bit.
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic [WIDTH:0]       part_rem;
    logic                 q_bit;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        // Operand magnitudes (two's complement negation, modulo 2^WIDTH).
        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

        // One restoring step: shift in the next dividend bit and trial-compare.
        part_rem = {rem_q, dvd_q[WIDTH-1]};
        q_bit    = (part_rem >= {1'b0, dvs_q});

        // Final sign correction of the unsigned result.
        quo_fix = neg_quo_q ? -dvd_q : dvd_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    dvd_d     = mag1;
                    dvs_d     = mag2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                    state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end

            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = '0;
                    state_d  = S_END;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = S_END;
                end else begin
                    // When q_bit is set the difference is below the divisor,
                    // so the low WIDTH bits of the subtraction are exact.
                    rem_d = q_bit ? (part_rem[WIDTH-1:0] - dvs_q) : part_rem[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_END: begin
                // Hold the result until the execute stage drops its request.
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == S_END);

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; the result is 2*WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port signed_div_i, input, 1, where 1 means a signed (DIV) operation and 0 an unsigned (DIVU) operation.
REQ-005 The block SHALL have port opdata1_i, input, WIDTH, the dividend.
REQ-006 The block SHALL have port opdata2_i, input, WIDTH, the divisor.
REQ-007 The block SHALL have port start_i, input, 1, the operation request, held high by the execute stage until ready_o is seen.
REQ-008 The block SHALL have port annul_i, input, 1, which cancels an in-flight or requested operation (flush or exception).
REQ-009 The block SHALL have port result_o, output, 2*WIDTH, holding {remainder, quotient}; the upper half goes to HI and the lower half to LO.
REQ-010 The block SHALL have port ready_o, output, 1, high when result_o is valid.

Function
REQ-011 The block SHALL implement four states: IDLE, BYZERO, ON and END.
REQ-012 In IDLE with start_i=1 and annul_i=0, the block SHALL latch the operands.
  - It SHALL convert each operand to its magnitude when signed_div_i=1 and that operand's MSB=1.
  - It SHALL go to BYZERO if opdata2_i=0, else to ON with the step counter cleared to 0.
REQ-013 In IDLE, start_i=0 or annul_i=1 SHALL leave the state unchanged.
REQ-014 In ON, each cycle SHALL perform one restoring shift-subtract step and increment the counter, with no annul_i.
  - Step: shift the partial remainder left 1 bit and bring in the next dividend MSB.
  - If the result is at least the divisor magnitude, subtract the divisor and shift in a quotient bit of 1; otherwise shift in 0.
REQ-015 In ON with counter=WIDTH, the block SHALL apply sign correction and go to END, registering result_o and setting ready_o=1.
  - Quotient is negated when signed_div_i=1 and the operand signs differ.
  - Remainder takes the sign of the dividend.
REQ-016 In BYZERO, the block SHALL set result_o to all zeros and go to END with ready_o=1 on the next edge.
REQ-017 Latency SHALL be WIDTH+2 edges from the start-sampling edge to ready_o=1 (34 for WIDTH=32), and 2 edges for divide-by-zero.
REQ-018 In END, the block SHALL hold result_o and ready_o=1 while start_i=1.
  - On start_i=0 it SHALL return to IDLE with ready_o=0.
  - result_o SHALL keep its value until the next completion.
REQ-019 annul_i=1 in ON or BYZERO SHALL force IDLE on the next edge, with ready_o=0 and result_o unchanged.
REQ-020 start_i edges while in ON or BYZERO SHALL be ignored; operand changes after the sampling edge SHALL NOT affect the result.
REQ-021 Signed overflow (most-negative / -1) SHALL yield quotient 0x80000000 and remainder 0, with no exception output.
REQ-022 Widths: the internal partial remainder SHALL be WIDTH+1 bits, and all negation SHALL be two's complement modulo 2^WIDTH.

Reset
REQ-023 rst=0 SHALL, immediately and independent of clk, force state=IDLE, counter=0, result_o=0 and ready_o=0.
REQ-024 Reset asserted mid-operation SHALL abort the operation; after release, the block SHALL accept a new start_i with no residual state.

Verification
REQ-025 Unsigned 100 / 7 -> ready_o high 34 edges after start; result_o = {0x00000002, 0x0000000E}.
REQ-026 Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF -> result_o = {0x00000000, 0x80000000}.
REQ-028 Divisor 0 with dividend 0x12345678 -> ready_o high 2 edges after start; result_o = 0.
REQ-029 annul_i pulsed at step 10 of 5 / 1 -> IDLE next edge, ready_o stays 0, result_o unchanged.
  - A following 9 / 3 SHALL complete to {0x00000000, 0x00000003}.
REQ-030 rst low asynchronously at step 20 -> result_o=0 and ready_o=0 immediately.
  - After release, holding start_i high through END SHALL keep ready_o=1.
  - Dropping start_i SHALL return the block to IDLE on the next edge.
